// File: rtl/serial_pkg.sv
// Shared definitions for the serial blocks: receiver FSM states, the
// Wishbone register map and the STATUS register bit positions.
package serial_pkg;

    localparam int unsigned WB_W = 32;

    // Receiver deframing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Register index, decoded from wb_addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // STATUS register bit positions
    localparam int unsigned ST_VALID     = 0;
    localparam int unsigned ST_OVERRUN   = 1;
    localparam int unsigned ST_FRAME_ERR = 2;

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, rst_n (async active-low, both flops load RESET_VAL),
//        d (asynchronous input), q (synchronized output).
module serial_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serialrx.sv
// UART receiver: deframes start + FRAME data bits (LSB first) + one stop bit
// from uart_rx into a one-entry buffer drained over a pipelined Wishbone slave.
// Ports: clk, rst_n (async active-low); uart_rx (idle-high serial line);
//        irq (buffer holds an unread byte); wb_addr/wb_data_w/wb_we/wb_stb/
//        wb_cyc (bus request); wb_data_r/wb_ack (registered response);
//        wb_stall (never stalls).
module serialrx #(
    parameter int unsigned DIVIDE = 2,
    parameter int unsigned FRAME  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        irq,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data_w,
    output logic [31:0] wb_data_r,
    input  logic        wb_we,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        wb_stall
);
    import serial_pkg::*;

    localparam int unsigned DW   = $clog2(DIVIDE);
    localparam int unsigned IW   = $clog2(FRAME + 1);
    localparam int unsigned HALF = DIVIDE / 2;

    localparam logic [DW-1:0] HALF_M1  = DW'(HALF - 1);
    localparam logic [DW-1:0] FULL_M1  = DW'(DIVIDE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(FRAME - 1);

    logic            rxs;
    rx_state_t       state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [FRAME-1:0] shift_q, shift_d;
    logic            stop_ok, stop_bad;

    logic [1:0]      prime_q;
    logic            armed_q;

    logic [FRAME-1:0] buf_q;
    logic            valid_q, overrun_q, frame_err_q;
    logic [WB_W-1:0] rx_count_q;

    logic            acc, pop, clr_ov, clr_fe;
    logic [1:0]      reg_idx;
    logic [WB_W-1:0] rd_data;
    logic            unused_bits;

    serial_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rxs)
    );

    // Arm start detection only once the line has been seen high after the
    // synchronizer has flushed its reset value, so a line held low through
    // reset is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_q <= 2'd0;
            armed_q <= 1'b0;
        end else if (prime_q != 2'd2) begin
            prime_q <= prime_q + 2'd1;
        end else if (rxs) begin
            armed_q <= 1'b1;
        end
    end

    // Deframer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Deframer next state; stop_ok/stop_bad strobe on the stop sample
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !rxs) begin
                    state_d = START;
                    div_d   = '0;
                end
            end
            START: begin
                if (div_q == HALF_M1) begin
                    div_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DATA: begin
                if (div_q == FULL_M1) begin
                    div_d   = '0;
                    // Shift in from the top: after FRAME samples bit 0 is the first bit
                    shift_d = FRAME'({rxs, shift_q} >> 1);
                    if (idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            STOP: begin
                if (div_q == FULL_M1) begin
                    div_d    = '0;
                    state_d  = IDLE;
                    stop_ok  = rxs;
                    stop_bad = !rxs;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus decode and read mux
    assign reg_idx = wb_addr[3:2];

    always_comb begin
        acc     = wb_stb && wb_cyc;
        pop     = acc && !wb_we && (reg_idx == REG_DATA) && valid_q;
        clr_ov  = acc && wb_we && (reg_idx == REG_STATUS) && wb_data_w[ST_OVERRUN];
        clr_fe  = acc && wb_we && (reg_idx == REG_STATUS) && wb_data_w[ST_FRAME_ERR];
        rd_data = '0;
        case (reg_idx)
            REG_DATA: begin
                if (valid_q) begin
                    rd_data     = WB_W'(buf_q);
                    rd_data[31] = 1'b1;
                end
            end
            REG_STATUS: begin
                rd_data[ST_VALID]     = valid_q;
                rd_data[ST_OVERRUN]   = overrun_q;
                rd_data[ST_FRAME_ERR] = frame_err_q;
            end
            REG_COUNT: rd_data = rx_count_q;
            default:   rd_data = '0;
        endcase
    end

    // Receive buffer, sticky flags and frame counter; flag sets win over W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_count_q  <= '0;
        end else begin
            if (stop_ok && (!valid_q || pop)) begin
                buf_q      <= shift_q;
                valid_q    <= 1'b1;
                rx_count_q <= rx_count_q + WB_W'(1);
            end else if (pop) begin
                valid_q <= 1'b0;
            end

            if (stop_ok && valid_q && !pop) begin
                overrun_q <= 1'b1;
            end else if (clr_ov) begin
                overrun_q <= 1'b0;
            end

            if (stop_bad) begin
                frame_err_q <= 1'b1;
            end else if (clr_fe) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    // Registered bus response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack    <= 1'b0;
            wb_data_r <= '0;
        end else begin
            wb_ack <= acc;
            if (acc) begin
                wb_data_r <= rd_data;
            end
        end
    end

    assign irq      = valid_q;
    assign wb_stall = 1'b0;

    assign unused_bits = ^{wb_addr[31:4], wb_addr[1:0], wb_data_w[31:3], wb_data_w[0]};

endmodule

// File: tb/tb_serialrx.sv
// Bench for serialrx (DIVIDE=4, FRAME=8): directed serial frames and bus
// accesses, a frame-level reference model checked every cycle, and literal
// expectations on each register read.
module tb_serialrx;

    localparam int D        = 4;
    localparam int F        = 8;
    localparam int H        = D / 2;
    // Edge of the stop sample relative to the edge after which the start bit
    // is driven: 2 sync flops + 1 detection edge + half bit + (F+1) bits.
    localparam int STOP_OFS = 3 + H + (F + 1) * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        irq;
    logic [31:0] wb_addr;
    logic [31:0] wb_data_w;
    logic [31:0] wb_data_r;
    logic        wb_we, wb_stb, wb_cyc;
    logic        wb_ack, wb_stall;

    serialrx #(.DIVIDE(D), .FRAME(F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .irq       (irq),
        .wb_addr   (wb_addr),
        .wb_data_w (wb_data_w),
        .wb_data_r (wb_data_r),
        .wb_we     (wb_we),
        .wb_stb    (wb_stb),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int last_k = 0;
    logic live = 1'b0;

    typedef struct {
        int         e;
        logic [7:0] b;
        logic       s;
    } ev_t;
    ev_t evq[$];

    // Model state: what the CPU-visible register file must contain
    logic        m_valid, m_ovr, m_ferr;
    logic [7:0]  m_byte;
    logic [31:0] m_cnt;
    logic        exp_ack, exp_rd, exp_irq;
    logic [31:0] exp_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: bus effects first, then any frame whose stop sample
    // falls on this edge, so a same-cycle pop frees the buffer and sets beat W1C.
    always @(posedge clk) begin
        int          cur;
        logic        v, ov, fe, pop;
        logic [7:0]  by;
        logic [31:0] cnt, d;
        cur = edge_n + 1;
        edge_n <= cur;
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_ovr    <= 1'b0;
            m_ferr   <= 1'b0;
            m_byte   <= 8'd0;
            m_cnt    <= 32'd0;
            exp_ack  <= 1'b0;
            exp_rd   <= 1'b0;
            exp_irq  <= 1'b0;
            exp_data <= 32'd0;
            evq.delete();
        end else begin
            v = m_valid; ov = m_ovr; fe = m_ferr; by = m_byte; cnt = m_cnt;
            pop = 1'b0; d = 32'd0;
            if (wb_stb && wb_cyc) begin
                if (!wb_we) begin
                    case (wb_addr[3:2])
                        2'd0: begin
                            d   = m_valid ? {1'b1, 23'd0, m_byte} : 32'd0;
                            pop = m_valid;
                        end
                        2'd1:    d = {29'd0, m_ferr, m_ovr, m_valid};
                        2'd2:    d = m_cnt;
                        default: d = 32'd0;
                    endcase
                end else if (wb_addr[3:2] == 2'd1) begin
                    if (wb_data_w[1]) ov = 1'b0;
                    if (wb_data_w[2]) fe = 1'b0;
                end
            end
            if (pop) v = 1'b0;
            if (evq.size() > 0 && evq[0].e == cur) begin
                if (evq[0].s) begin
                    if (!m_valid || pop) begin
                        by  = evq[0].b;
                        v   = 1'b1;
                        cnt = cnt + 32'd1;
                    end else begin
                        ov = 1'b1;
                    end
                end else begin
                    fe = 1'b1;
                end
                void'(evq.pop_front());
            end
            m_valid  <= v;
            m_ovr    <= ov;
            m_ferr   <= fe;
            m_byte   <= by;
            m_cnt    <= cnt;
            exp_ack  <= wb_stb && wb_cyc;
            exp_rd   <= wb_stb && wb_cyc && !wb_we;
            exp_irq  <= v;
            exp_data <= d;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (live && rst_n) begin
            check("cyc_ack", 32'(wb_ack), 32'(exp_ack));
            check("cyc_irq", 32'(irq), 32'(exp_irq));
            check("cyc_stall", 32'(wb_stall), 32'd0);
            if (exp_ack && exp_rd) check("cyc_rdata", wb_data_r, exp_data);
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic sb);
        ev_t ev;
        @(posedge clk); #1;
        last_k = edge_n;
        ev.e = edge_n + STOP_OFS;
        ev.b = b;
        ev.s = sb;
        evq.push_back(ev);
        uart_rx = 1'b0;
        repeat (D) @(posedge clk);
        #1;
        for (int i = 0; i < F; i++) begin
            uart_rx = b[i];
            repeat (D) @(posedge clk);
            #1;
        end
        uart_rx = sb;
        repeat (D) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic wb_read(input logic [1:0] idx, output logic [31:0] d);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_addr = {28'd0, idx, 2'b00};
        @(posedge clk); #1;
        wb_stb = 1'b0;
        check("rd_ack", 32'(wb_ack), 32'd1);
        d = wb_data_r;
    endtask

    task automatic wb_write(input logic [1:0] idx, input logic [31:0] d);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = {28'd0, idx, 2'b00};
        wb_data_w = d;
        @(posedge clk); #1;
        wb_stb = 1'b0; wb_we = 1'b0;
        check("wr_ack", 32'(wb_ack), 32'd1);
    endtask

    logic [31:0] rv, rv5;
    logic [7:0]  b6;
    int          got;

    initial begin
        rst_n = 1'b0; uart_rx = 1'b1;
        wb_addr = 32'd0; wb_data_w = 32'd0;
        wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        rst_n = 1'b1; live = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset register contents, and a strobe outside a cycle is ignored
        wb_read(2'd1, rv); check("rst_status", rv, 32'h0);
        wb_read(2'd2, rv); check("rst_count", rv, 32'h0);
        wb_read(2'd0, rv); check("rst_data", rv, 32'h0);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        check("nocyc_ack", 32'(wb_ack), 32'd0);
        wb_cyc = 1'b1;

        // Basic frame and irq timing
        send_frame(8'hA5, 1'b1);
        got = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (irq) begin
                got = edge_n;
                break;
            end
        end
        check("irq_edge", 32'(got), 32'(last_k + 41));
        wb_read(2'd0, rv); check("a5_data", rv, 32'h800000A5);
        wb_read(2'd0, rv); check("a5_data2", rv, 32'h0);
        wb_read(2'd2, rv); check("a5_count", rv, 32'd1);

        // Overrun
        send_frame(8'h3C, 1'b1);
        send_frame(8'h7E, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        wb_read(2'd1, rv); check("ovr_status", rv, 32'h3);
        wb_read(2'd0, rv); check("ovr_data", rv, 32'h8000003C);
        wb_read(2'd2, rv); check("ovr_count", rv, 32'd2);
        wb_write(2'd1, 32'h2);
        wb_read(2'd1, rv); check("ovr_clr", rv, 32'h0);

        // Framing error
        send_frame(8'h55, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("fe_irq", 32'(irq), 32'd0);
        wb_read(2'd1, rv); check("fe_status", rv, 32'h4);
        wb_read(2'd2, rv); check("fe_count", rv, 32'd2);
        wb_write(2'd1, 32'h4);
        wb_read(2'd1, rv); check("fe_clr", rv, 32'h0);

        // One-cycle glitch
        @(posedge clk); #1;
        uart_rx = 1'b0;
        @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        wb_read(2'd1, rv); check("glitch_status", rv, 32'h0);

        // Pop in the same cycle as the stop sample of the next frame
        send_frame(8'h42, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        fork
            send_frame(8'h81, 1'b1);
            begin
                @(posedge clk); #1;
                repeat (39) @(posedge clk);
                #1;
                wb_read(2'd0, rv5);
            end
        join
        check("pop_old", rv5, 32'h80000042);
        repeat (2) @(posedge clk);
        #1;
        wb_read(2'd1, rv); check("pop_status", rv, 32'h1);
        wb_read(2'd0, rv); check("pop_new", rv, 32'h80000081);
        wb_read(2'd2, rv); check("pop_count", rv, 32'd4);

        // Async reset during data bit 3, line held low through release
        send_frame(8'h99, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_irq", 32'(irq), 32'd1);
        b6 = 8'h6B;
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (D) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            uart_rx = b6[i];
            repeat (D) @(posedge clk);
            #1;
        end
        uart_rx = b6[3];
        wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h4;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        check("pre_rst_ack", 32'(wb_ack), 32'd1);
        rst_n = 1'b0; uart_rx = 1'b0;
        #1;
        check("async_irq", 32'(irq), 32'd0);
        check("async_ack", 32'(wb_ack), 32'd0);
        check("async_data", wb_data_r, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        wb_read(2'd1, rv); check("low_status", rv, 32'h0);
        wb_read(2'd2, rv); check("low_count", rv, 32'd0);
        wb_read(2'd0, rv); check("low_data", rv, 32'h0);
        uart_rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send_frame(8'h0F, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        wb_read(2'd0, rv); check("post_data", rv, 32'h8000000F);
        wb_read(2'd2, rv); check("post_count", rv, 32'd1);
        wb_read(2'd1, rv); check("post_status", rv, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
